// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the multicycle ALU.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SRA = 5'b00110;
  localparam logic [4:0] OP_SHL = 5'b00111;
  localparam logic [4:0] OP_ROR = 5'b01000;
  localparam logic [4:0] OP_ROL = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;
  localparam logic [4:0] OP_INC = 5'b11111;

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIX} state_t;

endpackage

// File: rtl/seq_div_core.sv
// Signed non-restoring divider on operand magnitudes; quo/rem are the
// corrected, sign-fixed values once fin is high.
module seq_div_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic             run_q;
  logic             sa_q, sb_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   p_sh, p_d, p_fix;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    // Partial remainder sign picks add or subtract; quotient bit is its complement.
    p_sh  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    p_d   = p_q[WIDTH] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
    q_d   = {q_q[WIDTH-2:0], ~p_d[WIDTH]};
    p_fix = p_q[WIDTH] ? (p_q + {1'b0, d_q}) : p_q;
    quo   = (sa_q ^ sb_q) ? (~q_q + WIDTH'(1)) : q_q;
    rem   = sa_q ? (~p_fix[WIDTH-1:0] + WIDTH'(1)) : p_fix[WIDTH-1:0];
    fin   = run_q && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      run_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      d_q   <= '0;
      p_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      run_q <= 1'b1;
      sa_q  <= a[WIDTH-1];
      sb_q  <= b[WIDTH-1];
      d_q   <= b_mag;
      p_q   <= '0;
      q_q   <= a_mag;
      cnt_q <= '0;
    end else if (run_q && (cnt_q != CNT_LAST)) begin
      p_q   <= p_d;
      q_q   <= q_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/shift/add ops, Booth multiplier and
// signed divider behind a start/busy/done handshake.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         control,
  input  logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_t state_q, state_d;

  logic [4:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH:0]     acc_q, mcand_q;
  logic [WIDTH-1:0]   mq_q;
  logic               qm1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q, done_q, dz_q;

  logic               accept, is_mul, is_div, b_zero, div_load, finish;
  logic [WIDTH:0]     acc_sel, acc_d;
  logic [WIDTH-1:0]   mq_d;
  logic               qm1_d;
  logic [SHAMT_W-1:0] shamt;
  logic [2*WIDTH-1:0] rot_r, rot_l, fin_result;
  logic [WIDTH-1:0]   alu_lo;
  logic               div_fin;
  logic [WIDTH-1:0]   div_quo, div_rem;

  seq_div_core #(.WIDTH(WIDTH)) u_div (
    .clock (clock),
    .clear (clear),
    .load  (div_load),
    .a     (y),
    .b     (b),
    .fin   (div_fin),
    .quo   (div_quo),
    .rem   (div_rem)
  );

  always_comb begin
    accept   = (state_q == IDLE) && start;
    is_mul   = (control == OP_MUL);
    is_div   = (control == OP_DIV);
    b_zero   = (b == '0);
    div_load = accept && is_div && !b_zero;
    finish   = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul)                 state_d = MUL;
          else if (is_div && !b_zero) state_d = DIV;
          else                        state_d = EXEC;
        end
      end
      EXEC: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      MUL: begin
        if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      DIV: begin
        if (div_fin) state_d = FIX;
      end
      FIX: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Booth step: add/sub multiplicand per {q0, q-1}, then arithmetic shift of {acc, mq, q-1}.
  always_comb begin
    case ({mq_q[0], qm1_q})
      2'b01:   acc_sel = acc_q + mcand_q;
      2'b10:   acc_sel = acc_q - mcand_q;
      default: acc_sel = acc_q;
    endcase
    {acc_d, mq_d, qm1_d} = {acc_sel[WIDTH], acc_sel, mq_q};
  end

  always_comb begin
    shamt = b_q[SHAMT_W-1:0];
    rot_r = {a_q, a_q} >> shamt;
    rot_l = {a_q, a_q} << shamt;
    case (op_q)
      OP_AND:  alu_lo = a_q & b_q;
      OP_SHR:  alu_lo = a_q >> shamt;
      OP_SRA:  alu_lo = $signed(a_q) >>> shamt;
      OP_SHL:  alu_lo = a_q << shamt;
      OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
      OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
      OP_NEG:  alu_lo = ~a_q + WIDTH'(1);
      OP_NOT:  alu_lo = ~a_q;
      OP_ADD:  alu_lo = a_q + b_q;
      OP_SUB:  alu_lo = a_q - b_q;
      OP_INC:  alu_lo = a_q + WIDTH'(1);
      default: alu_lo = a_q | b_q;
    endcase
    case (state_q)
      MUL:     fin_result = {acc_q[WIDTH-1:0], mq_q};
      FIX:     fin_result = {div_rem, div_quo};
      default: fin_result = (op_q == OP_DIV) ? {a_q, {WIDTH{1'b1}}}
                                             : {{WIDTH{1'b0}}, alu_lo};
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q    <= control;
        a_q     <= y;
        b_q     <= b;
        acc_q   <= '0;
        mcand_q <= {b[WIDTH-1], b};
        mq_q    <= y;
        qm1_q   <= 1'b0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        dz_q    <= 1'b0;
      end
      if ((state_q == MUL) && (cnt_q != CNT_LAST)) begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
        qm1_q <= qm1_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (finish) begin
        result_q <= fin_result;
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
        dz_q     <= (state_q == EXEC) && (op_q == OP_DIV);
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;

  localparam logic [4:0] C_ADD = 5'b00011, C_SUB = 5'b00100, C_SHR = 5'b00101,
                         C_SRA = 5'b00110, C_SHL = 5'b00111, C_ROR = 5'b01000,
                         C_ROL = 5'b01001, C_AND = 5'b01010, C_OR  = 5'b01011,
                         C_MUL = 5'b01111, C_DIV = 5'b10000, C_NEG = 5'b10001,
                         C_NOT = 5'b10010, C_INC = 5'b11111;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  control = '0;
  logic [31:0] y = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .control  (control),
    .y        (y),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  task automatic model(input logic [4:0] op, input logic [31:0] ya, input logic [31:0] bb,
                       output logic [63:0] res, output logic dz, output int lat);
    int          amt;
    logic [31:0] r;
    longint      sy, sd, q, rm;
    amt = int'(bb[4:0]);
    dz  = 1'b0;
    lat = 1;
    r   = ya | bb;
    res = '0;
    case (op)
      C_AND: r = ya & bb;
      C_SHR: r = ya >> amt;
      C_SRA: r = 32'($signed(ya) >>> amt);
      C_SHL: r = ya << amt;
      C_ROR: begin r = ya; repeat (amt) r = {r[0], r[31:1]}; end
      C_ROL: begin r = ya; repeat (amt) r = {r[30:0], r[31]}; end
      C_NEG: r = 32'(0 - ya);
      C_NOT: r = ~ya;
      C_ADD: r = ya + bb;
      C_SUB: r = ya - bb;
      C_INC: r = ya + 32'd1;
      default: r = ya | bb;
    endcase
    res = {32'd0, r};
    if (op == C_MUL) begin
      sy  = longint'($signed(ya));
      sd  = longint'($signed(bb));
      res = 64'(sy * sd);
      lat = 33;
    end else if (op == C_DIV) begin
      if (bb == 32'd0) begin
        res = {ya, 32'hFFFF_FFFF};
        dz  = 1'b1;
      end else begin
        sy  = longint'($signed(ya));
        sd  = longint'($signed(bb));
        q   = sy / sd;
        rm  = sy % sd;
        res = {rm[31:0], q[31:0]};
        lat = 34;
      end
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] ya, input logic [31:0] bb,
                        input int intrude_at);
    logic [63:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
    int          n;
    model(op, ya, bb, exp_res, exp_dz, exp_lat);
    @(negedge clock);
    start = 1'b1; control = op; y = ya; b = bb;
    @(posedge clock); #1;
    start = 1'b0; control = 5'($urandom); y = $urandom; b = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("done_pulse_width", 64'(done), 64'd0);
    n = 0;
    while (!done && n < 100) begin
      if (n == intrude_at) begin
        start = 1'b1; control = C_ADD; y = $urandom; b = $urandom;
      end
      @(posedge clock); #1;
      start = 1'b0;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("result", result, exp_res);
    chk("div_zero", 64'(div_zero), 64'(exp_dz));
    chk("busy_at_done", 64'(busy), 64'd0);
    $display("op=%b y=%h b=%h -> result=%h dz=%0d lat=%0d", op, ya, bb, result, div_zero, n);
  endtask

  logic [4:0]  valid_ops [14];
  logic [4:0]  rop;
  logic [31:0] ry, rb;
  logic        saw_done;

  initial begin
    valid_ops = '{C_ADD, C_SUB, C_SHR, C_SRA, C_SHL, C_ROR, C_ROL,
                  C_AND, C_OR, C_MUL, C_DIV, C_NEG, C_NOT, C_INC};
    repeat (3) @(posedge clock);
    @(negedge clock) clear = 1'b1;
    @(posedge clock); #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_div_zero", 64'(div_zero), 64'd0);
    chk("reset_result", result, 64'd0);

    run_op(C_ADD, 32'd7, 32'd5, -1);
    run_op(C_MUL, 32'hFFFF_FFFD, 32'd7, -1);
    run_op(C_MUL, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(C_DIV, 32'd9, 32'd0, -1);
    run_op(C_ADD, 32'd1, 32'd2, -1);
    run_op(C_SRA, 32'h8000_0000, 32'd33, -1);
    run_op(C_ROL, 32'h8000_0001, 32'd1, -1);
    run_op(C_ROR, 32'h8000_0001, 32'd0, -1);
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(C_DIV, 32'd7, 32'hFFFF_FFFE, -1);
    run_op(5'b00000, 32'h0F0F_0000, 32'h0000_00F0, -1);
    run_op(C_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5);

    // Reset in the middle of a multiply discards it asynchronously.
    @(negedge clock);
    start = 1'b1; control = C_MUL; y = 32'd1234; b = 32'd5678;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 clear = 1'b0;
    #1;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_done", 64'(done), 64'd0);
    chk("clear_result", result, 64'd0);
    @(negedge clock) clear = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_clear", 64'(saw_done), 64'd0);
    run_op(C_ADD, 32'hFFFF_FFFF, 32'd2, -1);

    for (int i = 0; i < 200; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 5'($urandom) : valid_ops[$urandom_range(0, 13)];
      ry  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ry = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ry = 32'($urandom_range(0, 20)) - 32'd10; rb = 32'($urandom_range(0, 20)) - 32'd10; end
        default: ;
      endcase
      run_op(rop, ry, rb, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
